nco_iq_mix_dec: RTL and testbench



---
 rtl/nco_iq_mix_dec.sv | 136 +++++++++++++
 tb/tb_nco_iq_mix_dec.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nco_iq_mix_dec.sv
// rtl/nco_iq_mix_dec.sv - NCO quadrature mixer with integrate-and-dump decimation
// Optional output saturation: define IQ_MIX_DEC_SAT_EN (default build wraps to OW bits).
module nco_iq_mix_dec #(
  parameter int MPR   = 16,
  parameter int DW    = 14,
  parameter int OW    = 16,
  parameter int DECW  = 8,
  parameter int SHIFT = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clken,
  input  logic signed [DW-1:0]   adc_data_i,
  input  logic                   adc_valid_i,
  input  logic signed [MPR-1:0]  fcos_i,
  input  logic signed [MPR-1:0]  fsin_i,
  input  logic                   nco_valid_i,
  input  logic        [DECW-1:0] dec_factor_i,
  output logic signed [OW-1:0]   i_o,
  output logic signed [OW-1:0]   q_o,
  output logic                   out_valid
);

  localparam int PW = DW + MPR;
  localparam int AW = PW + DECW;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (SHIFT - 1);
`ifdef IQ_MIX_DEC_SAT_EN
  localparam logic signed [AW-1:0] HI = AW'((2 ** (OW - 1)) - 1);
  localparam logic signed [AW-1:0] LO = -AW'(2 ** (OW - 1));
`endif

  logic signed [DW-1:0]  adc_r;
  logic signed [MPR-1:0] cos_r;
  logic signed [MPR-1:0] sin_r;
  logic                  v1;

  logic signed [PW-1:0]  pi_r;
  logic signed [PW-1:0]  pq_r;
  logic                  v2;

  logic        [DECW-1:0] cnt;
  logic        [DECW-1:0] d_lat;
  logic signed [AW-1:0]   acc_i;
  logic signed [AW-1:0]   acc_q;
  logic                   dump;

  logic        [DECW-1:0] d_new;
  logic        [DECW-1:0] d_blk;
  logic                   last;
  logic signed [AW-1:0]   ext_i;
  logic signed [AW-1:0]   ext_q;
  logic signed [AW-1:0]   new_i;
  logic signed [AW-1:0]   new_q;

  // Round half up, then either clamp or wrap to the output width.
  function automatic logic signed [OW-1:0] limit(input logic signed [AW-1:0] a);
`ifdef IQ_MIX_DEC_SAT_EN
    logic signed [AW-1:0] r;
    r = (a + HALF) >>> SHIFT;
    if (r > HI)      return OW'(HI);
    else if (r < LO) return OW'(LO);
    else             return OW'(r);
`else
    return OW'((a + HALF) >>> SHIFT);
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      adc_r <= '0;
      cos_r <= '0;
      sin_r <= '0;
      v1    <= 1'b0;
      pi_r  <= '0;
      pq_r  <= '0;
      v2    <= 1'b0;
    end else if (clken) begin
      adc_r <= adc_data_i;
      cos_r <= fcos_i;
      sin_r <= fsin_i;
      v1    <= adc_valid_i & nco_valid_i;
      pi_r  <= adc_r * cos_r;
      pq_r  <= -(adc_r * sin_r);
      v2    <= v1;
    end
  end

  // A block's length is fixed by dec_factor_i as seen when its first product arrives.
  always_comb begin
    d_new = (dec_factor_i == '0) ? DECW'(1) : dec_factor_i;
    d_blk = (cnt == '0) ? d_new : d_lat;
    last  = (cnt == d_blk - DECW'(1));
    ext_i = {{DECW{pi_r[PW-1]}}, pi_r};
    ext_q = {{DECW{pq_r[PW-1]}}, pq_r};
    new_i = (cnt == '0) ? ext_i : acc_i + ext_i;
    new_q = (cnt == '0) ? ext_q : acc_q + ext_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      d_lat <= DECW'(1);
      acc_i <= '0;
      acc_q <= '0;
      dump  <= 1'b0;
    end else if (clken) begin
      dump <= 1'b0;
      if (v2) begin
        acc_i <= new_i;
        acc_q <= new_q;
        if (cnt == '0) d_lat <= d_new;
        if (last) begin
          cnt  <= '0;
          dump <= 1'b1;
        end else begin
          cnt <= cnt + DECW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_o       <= '0;
      q_o       <= '0;
      out_valid <= 1'b0;
    end else if (clken) begin
      out_valid <= dump;
      if (dump) begin
        i_o <= limit(acc_i);
        q_o <= limit(acc_q);
      end
    end
  end

endmodule

// File: tb/tb_nco_iq_mix_dec.sv
// tb/tb_nco_iq_mix_dec.sv - directed self-checking bench for nco_iq_mix_dec
module tb_nco_iq_mix_dec;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clken = 1'b0;
  logic signed [13:0] adc_data = '0;
  logic               adc_valid = 1'b0;
  logic signed [15:0] fcos = '0;
  logic signed [15:0] fsin = '0;
  logic               nco_valid = 1'b0;
  logic        [7:0]  dec_factor = 8'd1;
  logic signed [15:0] i_o;
  logic signed [15:0] q_o;
  logic               out_valid;

  int checks = 0;
  int failures = 0;
  int nstrobe, cecount, acc_cnt, first_ce, hold_err;
  int sv_i [32];
  int sv_q [32];

  nco_iq_mix_dec dut (
    .clk(clk), .reset(reset), .clken(clken),
    .adc_data_i(adc_data), .adc_valid_i(adc_valid),
    .fcos_i(fcos), .fsin_i(fsin), .nco_valid_i(nco_valid),
    .dec_factor_i(dec_factor),
    .i_o(i_o), .q_o(q_o), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic ce, input logic av, input logic nv);
    logic ov_before;
    clken = ce; adc_valid = av; nco_valid = nv;
    ov_before = out_valid;
    @(posedge clk); #1;
    if (ce) begin
      cecount++;
      if (av && nv) acc_cnt++;
      if (out_valid && !reset) begin
        if (nstrobe == 0) first_ce = cecount;
        if (nstrobe < 32) begin
          sv_i[nstrobe] = i_o;
          sv_q[nstrobe] = q_o;
        end
        nstrobe++;
      end
    end else if (out_valid !== ov_before) begin
      hold_err++;
    end
  endtask

  task automatic clear();
    reset = 1'b1;
    step(1, 0, 0);
    reset = 1'b0;
    nstrobe = 0; cecount = 0; acc_cnt = 0; first_ce = -1; hold_err = 0;
  endtask

  task automatic set_data(input int a, input int c, input int s);
    adc_data = 14'(a); fcos = 16'(c); fsin = 16'(s);
  endtask

  task automatic test_reset();
    clear();
    step(1, 0, 0);
    checks++; if (i_o !== 16'sd0) begin failures++; $display("FAIL reset_i got=%0d exp=0", i_o); end
    checks++; if (q_o !== 16'sd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q_o); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_d1();
    clear();
    dec_factor = 8'd1;
    set_data(8191, 32767, 0);
    for (int k = 0; k < 10; k++) step(1, 1, 1);
    checks++; if (first_ce != 4) begin failures++; $display("FAIL d1_latency got=%0d exp=4", first_ce); end
    checks++; if (nstrobe != 7) begin failures++; $display("FAIL d1_strobes got=%0d exp=7", nstrobe); end
    checks++; if (sv_i[0] != 16382) begin failures++; $display("FAIL d1_i got=%0d exp=16382", sv_i[0]); end
    checks++; if (sv_q[0] != 0) begin failures++; $display("FAIL d1_q got=%0d exp=0", sv_q[0]); end
    checks++; if (sv_i[6] != 16382) begin failures++; $display("FAIL d1_i_last got=%0d exp=16382", sv_i[6]); end
  endtask

  task automatic test_d4();
    clear();
    dec_factor = 8'd4;
    set_data(1000, 16384, -16384);
    for (int k = 0; k < 8; k++) step(1, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    checks++; if (nstrobe != 2) begin failures++; $display("FAIL d4_strobes got=%0d exp=2", nstrobe); end
    checks++; if (sv_i[1] != 4000) begin failures++; $display("FAIL d4_i got=%0d exp=4000", sv_i[1]); end
    checks++; if (sv_q[1] != 4000) begin failures++; $display("FAIL d4_q got=%0d exp=4000", sv_q[1]); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL d4_valid_clear got=%b exp=0", out_valid); end
    checks++; if (i_o !== 16'sd4000) begin failures++; $display("FAIL d4_hold got=%0d exp=4000", i_o); end
  endtask

  task automatic test_range();
    int exp_i;
`ifdef IQ_MIX_DEC_SAT_EN
    exp_i = 32767;
`else
    exp_i = -10;
`endif
    clear();
    dec_factor = 8'd4;
    set_data(8191, 32767, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    checks++; if (nstrobe != 1) begin failures++; $display("FAIL range_strobes got=%0d exp=1", nstrobe); end
    checks++; if (sv_i[0] != exp_i) begin failures++; $display("FAIL range_i got=%0d exp=%0d", sv_i[0], exp_i); end
  endtask

  task automatic test_random_gaps();
    clear();
    dec_factor = 8'd4;
    set_data(1000, 16384, -16384);
    for (int k = 0; k < 400 && acc_cnt < 8; k++)
      step(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
    checks++; if (acc_cnt != 8) begin failures++; $display("FAIL rnd_timeout accepts=%0d exp=8", acc_cnt); end
    for (int k = 0; k < 12; k++) step(1'(k % 2), 0, 0);
    checks++; if (nstrobe != 2) begin failures++; $display("FAIL rnd_strobes got=%0d exp=2", nstrobe); end
    checks++; if (sv_i[0] != 4000 || sv_q[0] != 4000) begin failures++; $display("FAIL rnd_iq0 got=%0d/%0d exp=4000/4000", sv_i[0], sv_q[0]); end
    checks++; if (sv_i[1] != 4000 || sv_q[1] != 4000) begin failures++; $display("FAIL rnd_iq1 got=%0d/%0d exp=4000/4000", sv_i[1], sv_q[1]); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL rnd_hold got=%0d exp=0", hold_err); end
  endtask

  task automatic test_reset_mid();
    clear();
    dec_factor = 8'd4;
    set_data(1000, 16384, -16384);
    for (int k = 0; k < 4; k++) step(1, 1, 1);
    set_data(2000, 16384, -16384);
    step(1, 1, 1);
    step(1, 1, 1);
    step(1, 0, 0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid got=%b exp=1", out_valid); end
    reset = 1'b1;
    step(1, 0, 0);
    reset = 1'b0;
    checks++; if (i_o !== 16'sd0 || q_o !== 16'sd0) begin failures++; $display("FAIL rmid_zero got=%0d/%0d exp=0/0", i_o, q_o); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    nstrobe = 0;
    set_data(1000, 16384, -16384);
    for (int k = 0; k < 4; k++) step(1, 1, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    checks++; if (nstrobe != 1) begin failures++; $display("FAIL rmid_strobes got=%0d exp=1", nstrobe); end
    checks++; if (sv_i[0] != 4000 || sv_q[0] != 4000) begin failures++; $display("FAIL rmid_iq got=%0d/%0d exp=4000/4000", sv_i[0], sv_q[0]); end
  endtask

  task automatic test_dec_change();
    clear();
    dec_factor = 8'd4;
    set_data(1000, 16384, -16384);
    for (int k = 0; k < 3; k++) step(1, 1, 1);
    dec_factor = 8'd2;
    for (int k = 0; k < 5; k++) step(1, 1, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    checks++; if (nstrobe != 3) begin failures++; $display("FAIL dchg_strobes got=%0d exp=3", nstrobe); end
    checks++; if (sv_i[0] != 4000) begin failures++; $display("FAIL dchg_first got=%0d exp=4000", sv_i[0]); end
    checks++; if (sv_i[1] != 2000 || sv_q[2] != 2000) begin failures++; $display("FAIL dchg_next got=%0d/%0d exp=2000/2000", sv_i[1], sv_q[2]); end
    dec_factor = 8'd0;
    nstrobe = 0;
    for (int k = 0; k < 3; k++) step(1, 1, 1);
    for (int k = 0; k < 3; k++) step(1, 0, 0);
    checks++; if (nstrobe != 3) begin failures++; $display("FAIL dzero_strobes got=%0d exp=3", nstrobe); end
    checks++; if (sv_i[2] != 1000 || sv_q[2] != 1000) begin failures++; $display("FAIL dzero_iq got=%0d/%0d exp=1000/1000", sv_i[2], sv_q[2]); end
  endtask

  initial begin
    test_reset();
    test_d1();
    test_d4();
    test_range();
    test_random_gaps();
    test_reset_mid();
    test_dec_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
